// File: rtl/mem_data_arb.sv
// Round-robin arbiter sharing mem_data between CPU (0) and DMA/debug loader (1), with optional locked sequences.
// Optional MEM_ARB_ALIGN_CHECK_EN: odd-address grants are acknowledged but skip the memory and pulse err0/err1.
`ifndef ADDR_LEN
`define ADDR_LEN 16
`endif
`ifndef WORD_LEN
`define WORD_LEN 16
`endif

module mem_data_arb #(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 we0,
    input  logic                 lock0,
    input  logic [`ADDR_LEN-1:0] addr0,
    input  logic [`WORD_LEN-1:0] wdata0,
    output logic                 gnt0,
    output logic                 rvalid0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic                 lock1,
    input  logic [`ADDR_LEN-1:0] addr1,
    input  logic [`WORD_LEN-1:0] wdata1,
    output logic                 gnt1,
    output logic                 rvalid1,
    output logic [`WORD_LEN-1:0] rdata,
    output logic [`ADDR_LEN-1:0] mem_read_addr,
    output logic [`ADDR_LEN-1:0] mem_write_addr,
    output logic [`WORD_LEN-1:0] mem_data_in,
    output logic                 mem_write_en,
    input  logic [`WORD_LEN-1:0] mem_data_out
`ifdef MEM_ARB_ALIGN_CHECK_EN
    ,
    output logic                 err0,
    output logic                 err1
`endif
);

    typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [7:0]           lcnt_q, lcnt_d;
    logic                 rvalid0_q, rvalid1_q;
    logic [`WORD_LEN-1:0] rdata_q;
    logic                 g0, g1;
    logic                 sel_we, misal;
    logic [`ADDR_LEN-1:0] sel_addr;
    logic [`WORD_LEN-1:0] sel_wdata;
    logic                 own_req, own_lock;

    // Grants are suppressed during reset so nothing reaches the memory.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            case (state_q)
                UNLOCKED: begin
                    if (req0 && req1) begin
                        g0 = last_q;
                        g1 = !last_q;
                    end else begin
                        g0 = req0;
                        g1 = req1;
                    end
                end
                LOCKED0: g0 = req0;
                LOCKED1: g1 = req1;
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (g1) begin
            sel_addr  = addr1;
            sel_wdata = wdata1;
            sel_we    = we1;
        end else if (g0) begin
            sel_addr  = addr0;
            sel_wdata = wdata0;
            sel_we    = we0;
        end
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign misal = sel_addr[0];
`else
    assign misal = 1'b0;
`endif

    assign gnt0           = g0;
    assign gnt1           = g1;
    assign mem_read_addr  = sel_addr;
    assign mem_write_addr = sel_addr;
    assign mem_data_in    = sel_wdata;
    assign mem_write_en   = sel_we & ~misal;
    assign rvalid0        = rvalid0_q & ~rst;
    assign rvalid1        = rvalid1_q & ~rst;
    assign rdata          = rdata_q;

    always_comb begin
        state_d  = state_q;
        lcnt_d   = lcnt_q;
        last_d   = last_q;
        own_req  = (state_q == LOCKED1) ? req1  : req0;
        own_lock = (state_q == LOCKED1) ? lock1 : lock0;
        if (g0 || g1) last_d = g1;
        case (state_q)
            UNLOCKED: begin
                // With LOCK_MAX=1 the first locked grant already exhausts the budget.
                if (((g0 && lock0) || (g1 && lock1)) && (LOCK_MAX > 1)) begin
                    state_d = g1 ? LOCKED1 : LOCKED0;
                    lcnt_d  = 8'd1;
                end
            end
            LOCKED0, LOCKED1: begin
                if (!own_req || !own_lock || (lcnt_q == 8'(LOCK_MAX - 1))) begin
                    state_d = UNLOCKED;
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = UNLOCKED;
                lcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNLOCKED;
            lcnt_q    <= '0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            lcnt_q    <= lcnt_d;
            last_q    <= last_d;
            rvalid0_q <= g0 & ~we0 & ~misal;
            rvalid1_q <= g1 & ~we1 & ~misal;
            if ((g0 || g1) && !sel_we && !misal) rdata_q <= mem_data_out;
        end
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic err0_q, err1_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            err0_q <= g0 & misal;
            err1_q <= g1 & misal;
        end
    end
    assign err0 = err0_q;
    assign err1 = err1_q;
`endif

endmodule

// File: tb/tb_mem_data_arb.sv
// Scoreboard bench for mem_data_arb with a byte-cell memory model behind the mem_* ports (LOCK_MAX=3).
`timescale 1ns/1ps
`ifndef ADDR_LEN
`define ADDR_LEN 16
`endif
`ifndef WORD_LEN
`define WORD_LEN 16
`endif

module tb_mem_data_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_write_en;
    logic [15:0] rdata, mem_read_addr, mem_write_addr, mem_data_in, mem_data_out;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic        err0, err1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          port;
        logic [15:0] data;
    } rd_t;
    rd_t sbq[$];

    always #5 clk = ~clk;

    mem_data_arb #(.LOCK_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
        .mem_data_out(mem_data_out)
`ifdef MEM_ARB_ALIGN_CHECK_EN
        , .err0(err0), .err1(err1)
`endif
    );

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [15:0] exp_init(input logic [15:0] a);
        logic [15:0] b;
        b = a + 16'd1;
        return {init_byte(b), init_byte(a)};
    endfunction

    // Byte memory: combinational read of cells a, a+1; write commits at posedge.
    logic [7:0]  mem [65536];
    logic        mem_init_done = 1'b0;
    logic [15:0] rd_p1, wr_p1;
    assign rd_p1 = mem_read_addr + 16'd1;
    assign wr_p1 = mem_write_addr + 16'd1;
    assign mem_data_out = {mem[rd_p1], mem[mem_read_addr]};

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
            mem_init_done <= 1'b1;
        end else if (mem_write_en) begin
            mem[mem_write_addr] <= mem_data_in[7:0];
            mem[wr_p1]          <= mem_data_in[15:8];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0 = 1; we0 = 1; addr0 = 16'h0004; wdata0 = 16'h1111;
        @(negedge clk);
        n_tests++;
        if (mem_write_en !== 1'b0 || gnt0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: mem_write_en=%b gnt0=%b, required 0 0", mem_write_en, gnt0);
        end
        @(posedge clk);
        next_cycle();
        rst = 0; req0 = 0; we0 = 0;
        @(negedge clk);
        n_tests++;
        if ({gnt0, gnt1, rvalid0, rvalid1, rdata, mem_read_addr, mem_write_addr, mem_data_in, mem_write_en} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: gnt=%b%b rvalid=%b%b rdata=%h ra=%h wa=%h din=%h we=%b, required all 0",
                     gnt0, gnt1, rvalid0, rvalid1, rdata, mem_read_addr, mem_write_addr, mem_data_in, mem_write_en);
        end
    endtask

    task automatic test_first_tie();
        rd_t e;
        next_cycle();
        req0 = 1; we0 = 0; addr0 = 16'h0100;
        req1 = 1; we1 = 0; addr1 = 16'h0102;
        @(negedge clk);
        n_tests++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_read_addr !== 16'h0100) begin
            n_fail++;
            $display("FAIL tie_first: gnt0=%b gnt1=%b ra=%h, required 1 0 0100", gnt0, gnt1, mem_read_addr);
        end
        sbq.push_back('{0, exp_init(16'h0100)});
        next_cycle();
        req0 = 0;
        @(negedge clk);
        n_tests++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_second: gnt0=%b gnt1=%b, required 0 1", gnt0, gnt1);
        end
        e = sbq.pop_front();
        n_tests++;
        if (rvalid0 !== (e.port == 0) || rvalid1 !== (e.port == 1) || rdata !== e.data) begin
            n_fail++;
            $display("FAIL tie_rd0: rvalid0=%b rvalid1=%b rdata=%h, required port %0d data %h", rvalid0, rvalid1, rdata, e.port, e.data);
        end
        sbq.push_back('{1, exp_init(16'h0102)});
        next_cycle();
        req1 = 0;
        @(negedge clk);
        e = sbq.pop_front();
        n_tests++;
        if (rvalid0 !== (e.port == 0) || rvalid1 !== (e.port == 1) || rdata !== e.data) begin
            n_fail++;
            $display("FAIL tie_rd1: rvalid0=%b rvalid1=%b rdata=%h, required port %0d data %h", rvalid0, rvalid1, rdata, e.port, e.data);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (rvalid1 !== 1'b0 || rdata !== exp_init(16'h0102)) begin
            n_fail++;
            $display("FAIL tie_rvalid_once: rvalid1=%b rdata=%h, required 0 %h", rvalid1, rdata, exp_init(16'h0102));
        end
    endtask

    task automatic test_write_read();
        rd_t e;
        next_cycle();
        req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
        @(negedge clk);
        n_tests++;
        if (gnt0 !== 1'b1 || mem_write_en !== 1'b1 || mem_write_addr !== 16'h0010 || mem_data_in !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL wr_drive: gnt0=%b we=%b wa=%h din=%h, required 1 1 0010 beef", gnt0, mem_write_en, mem_write_addr, mem_data_in);
        end
        next_cycle();
        req0 = 0; we0 = 0;
        req1 = 1; we1 = 0; addr1 = 16'h0010;
        @(negedge clk);
        n_tests++;
        if (gnt1 !== 1'b1 || rvalid0 !== 1'b0 || mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_grant: gnt1=%b rvalid0=%b we=%b, required 1 0 0", gnt1, rvalid0, mem_write_en);
        end
        sbq.push_back('{1, 16'hBEEF});
        next_cycle();
        req1 = 0;
        @(negedge clk);
        e = sbq.pop_front();
        n_tests++;
        if (rvalid0 !== (e.port == 0) || rvalid1 !== (e.port == 1) || rdata !== e.data) begin
            n_fail++;
            $display("FAIL wr_rd_data: rvalid0=%b rvalid1=%b rdata=%h, required port %0d data %h", rvalid0, rvalid1, rdata, e.port, e.data);
        end
    endtask

    task automatic test_round_robin();
        logic exp_g0;
        next_cycle();
        req0 = 1; we0 = 1; addr0 = 16'h0200; wdata0 = 16'h0A0A;
        req1 = 1; we1 = 1; addr1 = 16'h0300; wdata1 = 16'h0B0B;
        exp_g0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if (gnt0 !== exp_g0 || gnt1 !== !exp_g0) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: gnt0=%b gnt1=%b, required %b %b", c, gnt0, gnt1, exp_g0, !exp_g0);
            end
            exp_g0 = !exp_g0;
            next_cycle();
        end
        req0 = 0; we0 = 0; req1 = 0; we1 = 0;
    endtask

    task automatic test_lock();
        rd_t e;
        req1 = 1; we1 = 0; addr1 = 16'h0040;
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 16'h0020;
        @(negedge clk);
        n_tests++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_first: gnt0=%b gnt1=%b, required 1 0", gnt0, gnt1);
        end
        sbq.push_back('{0, exp_init(16'h0020)});
        next_cycle();
        lock0 = 0; we0 = 1; wdata0 = 16'h1234;
        @(negedge clk);
        n_tests++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_write_en !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_hold: gnt0=%b gnt1=%b we=%b, required 1 0 1", gnt0, gnt1, mem_write_en);
        end
        e = sbq.pop_front();
        n_tests++;
        if (rvalid0 !== (e.port == 0) || rvalid1 !== (e.port == 1) || rdata !== e.data) begin
            n_fail++;
            $display("FAIL lock_rd: rvalid0=%b rvalid1=%b rdata=%h, required port %0d data %h", rvalid0, rvalid1, rdata, e.port, e.data);
        end
        next_cycle();
        req0 = 0; we0 = 0;
        @(negedge clk);
        n_tests++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_release: gnt0=%b gnt1=%b, required 0 1", gnt0, gnt1);
        end
        sbq.push_back('{1, exp_init(16'h0040)});
        next_cycle();
        addr1 = 16'h0020;
        @(negedge clk);
        e = sbq.pop_front();
        n_tests++;
        if (gnt1 !== 1'b1 || rvalid1 !== (e.port == 1) || rvalid0 !== (e.port == 0) || rdata !== e.data) begin
            n_fail++;
            $display("FAIL lock_rd1: gnt1=%b rvalid1=%b rdata=%h, required 1 port %0d data %h", gnt1, rvalid1, rdata, e.port, e.data);
        end
        sbq.push_back('{1, 16'h1234});
        next_cycle();
        req1 = 0;
        @(negedge clk);
        e = sbq.pop_front();
        n_tests++;
        if (rvalid0 !== (e.port == 0) || rvalid1 !== (e.port == 1) || rdata !== e.data) begin
            n_fail++;
            $display("FAIL lock_commit: rvalid1=%b rdata=%h, required port %0d data %h", rvalid1, rdata, e.port, e.data);
        end
        next_cycle();
    endtask

    task automatic test_lock_max();
        logic [4:0] exp_seq;
        exp_seq = 5'b01000; // bit c = 1 means gnt1 expected at cycle c (LSB first)
        req0 = 1; we0 = 1; lock0 = 1; addr0 = 16'h0050; wdata0 = 16'hAAAA;
        req1 = 1; we1 = 1; addr1 = 16'h0060; wdata1 = 16'h5555;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (gnt1 !== exp_seq[c] || gnt0 !== !exp_seq[c]) begin
                n_fail++;
                $display("FAIL lockmax_cycle%0d: gnt0=%b gnt1=%b, required %b %b", c, gnt0, gnt1, !exp_seq[c], exp_seq[c]);
            end
            next_cycle();
        end
        req0 = 0; we0 = 0; lock0 = 0; req1 = 0; we1 = 0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        rd_t e;
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 16'h0100;
        @(negedge clk);
        n_tests++;
        if (gnt0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_grant: gnt0=%b, required 1", gnt0);
        end
        next_cycle();
        rst = 1; we0 = 1; req1 = 1; we1 = 1; addr1 = 16'h0070;
        @(negedge clk);
        n_tests++;
        if (rvalid0 !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_hold: rvalid0=%b gnt=%b%b we=%b, required 0 00 0", rvalid0, gnt0, gnt1, mem_write_en);
        end
        next_cycle();
        rst = 0; req0 = 0; we0 = 0; lock0 = 0;
        we1 = 0; addr1 = 16'h0102;
        @(negedge clk);
        n_tests++;
        if (gnt1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_after: gnt1=%b rvalid0=%b rdata=%h, required 1 0 0000", gnt1, rvalid0, rdata);
        end
        sbq.push_back('{1, exp_init(16'h0102)});
        next_cycle();
        req1 = 0;
        @(negedge clk);
        e = sbq.pop_front();
        n_tests++;
        if (rvalid0 !== (e.port == 0) || rvalid1 !== (e.port == 1) || rdata !== e.data) begin
            n_fail++;
            $display("FAIL rstmid_rd: rvalid1=%b rdata=%h, required port %0d data %h", rvalid1, rdata, e.port, e.data);
        end
        next_cycle();
    endtask

`ifdef MEM_ARB_ALIGN_CHECK_EN
    task automatic test_align();
        req0 = 1; we0 = 1; addr0 = 16'h0011; wdata0 = 16'hCAFE;
        @(negedge clk);
        n_tests++;
        if (gnt0 !== 1'b1 || mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL align_wr: gnt0=%b we=%b, required 1 0", gnt0, mem_write_en);
        end
        next_cycle();
        req0 = 0; we0 = 0;
        req1 = 1; we1 = 0; addr1 = 16'h0013;
        @(negedge clk);
        n_tests++;
        if (err0 !== 1'b1 || err1 !== 1'b0 || rvalid0 !== 1'b0 || gnt1 !== 1'b1) begin
            n_fail++;
            $display("FAIL align_err0: err0=%b err1=%b rvalid0=%b gnt1=%b, required 1 0 0 1", err0, err1, rvalid0, gnt1);
        end
        next_cycle();
        req1 = 0;
        @(negedge clk);
        n_tests++;
        if (err1 !== 1'b1 || err0 !== 1'b0 || rvalid1 !== 1'b0 || rdata !== exp_init(16'h0102)) begin
            n_fail++;
            $display("FAIL align_err1: err1=%b err0=%b rvalid1=%b rdata=%h, required 1 0 0 %h", err1, err0, rvalid1, rdata, exp_init(16'h0102));
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (err1 !== 1'b0 || err0 !== 1'b0) begin
            n_fail++;
            $display("FAIL align_pulse: err0=%b err1=%b, required 0 0", err0, err1);
        end
    endtask
`else
    task automatic test_align();
        rd_t e;
        req0 = 1; we0 = 1; addr0 = 16'h0011; wdata0 = 16'hCAFE;
        @(negedge clk);
        n_tests++;
        if (gnt0 !== 1'b1 || mem_write_en !== 1'b1 || mem_write_addr !== 16'h0011) begin
            n_fail++;
            $display("FAIL odd_wr: gnt0=%b we=%b wa=%h, required 1 1 0011", gnt0, mem_write_en, mem_write_addr);
        end
        next_cycle();
        req0 = 0; we0 = 0;
        req1 = 1; we1 = 0; addr1 = 16'h0011;
        @(negedge clk);
        n_tests++;
        if (gnt1 !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_rd_grant: gnt1=%b, required 1", gnt1);
        end
        sbq.push_back('{1, 16'hCAFE});
        next_cycle();
        req1 = 0;
        @(negedge clk);
        e = sbq.pop_front();
        n_tests++;
        if (rvalid0 !== (e.port == 0) || rvalid1 !== (e.port == 1) || rdata !== e.data) begin
            n_fail++;
            $display("FAIL odd_rd: rvalid1=%b rdata=%h, required port %0d data %h", rvalid1, rdata, e.port, e.data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_tie();
        test_write_read();
        test_round_robin();
        test_lock();
        test_lock_max();
        test_reset_mid();
        test_align();
        n_tests++;
        if (sbq.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
